// File: rtl/ad_ctrl_pkg.sv
// Shared types and defaults for the ADC sample-clock controller.
package ad_ctrl_pkg;

   localparam int unsigned CLK_HZ_DEF = 200_000_000;
   localparam int unsigned NMIN_DEF   = 4;
   localparam int          W          = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_ARMED,
      S_RUN
   } state_t;

endpackage

// File: rtl/ad_period_div.sv
// Sequential restoring divider CLK_HZ / divisor, one quotient bit per cycle.
// Optional round-to-nearest of the period when AD_ROUND_EN is defined.
module ad_period_div
   import ad_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
   input  logic         clk_20b,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] q,
   output logic [W-1:0] n
);

   logic [W-1:0] rem;
   logic [W-1:0] dvs;
   logic [5:0]   step;
   logic         run;
   logic [W:0]   shl;
   logic [W:0]   diff;
   logic         rnd;

   assign shl  = {rem, q[W-1]};
   assign diff = shl - {1'b0, dvs};

`ifdef AD_ROUND_EN
   assign rnd = {rem, 1'b0} >= {1'b0, dvs};
`else
   assign rnd = 1'b0;
`endif

   // q starts as the dividend and fills with quotient bits from the right
   always_ff @(posedge clk_20b or negedge rst_n) begin
      if (!rst_n) begin
         rem  <= '0;
         dvs  <= '0;
         q    <= '0;
         n    <= '0;
         step <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem  <= '0;
            q    <= W'(CLK_HZ);
            dvs  <= divisor;
            step <= '0;
            run  <= 1'b1;
         end else if (run) begin
            if (step == 6'd32) begin
               n    <= q + W'(rnd);
               done <= 1'b1;
               run  <= 1'b0;
            end else begin
               step <= step + 1'b1;
               if (!diff[W]) begin
                  rem <= diff[W-1:0];
                  q   <= {q[W-2:0], 1'b1};
               end else begin
                  rem <= shl[W-1:0];
                  q   <= {q[W-2:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/ad_sample_ctrl.sv
// ADC sample-clock burst controller: rate config, period calc, burst run.
// Define AD_ROUND_EN to round the period to nearest instead of truncating.
module ad_sample_ctrl
   import ad_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEF,
   parameter int unsigned NMIN   = NMIN_DEF,
   parameter int          LEN_W  = 16
) (
   input  logic             clk_20b,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [31:0]      cfg_fx,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             ad_clk,
   output logic             smp_stb,
   output logic             done,
   output logic             cfg_err,
   output logic [31:0]      period_n
);

   localparam logic [W-1:0] FX_MAX = W'(CLK_HZ / NMIN);

   state_t           state;
   state_t           state_nx;
   logic [W-1:0]     cnt;
   logic [W-1:0]     div_n;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] smp_cnt;
   logic             hs;
   logic             fx_bad;
   logic             cfg_ok;
   logic             go;
   logic             last;
   logic             div_done;
   logic             clk_nx;

   assign cfg_ready = (state == S_IDLE) || (state == S_ARMED);
   assign busy      = (state == S_CALC) || (state == S_RUN);
   assign hs        = cfg_valid && cfg_ready;
   assign fx_bad    = (cfg_fx == '0) || (cfg_fx > FX_MAX);
   assign cfg_ok    = hs && !fx_bad;
   assign go        = (state == S_ARMED) && start && !hs;
   assign last      = (smp_cnt == len) && (cnt == period_n - 1'b1);
   // abort and burst end both force the clock low on the way out
   assign clk_nx    = (state == S_RUN) && !abort && !last
                      && (cnt >= (period_n >> 1));

   ad_period_div #(
      .CLK_HZ (CLK_HZ)
   ) u_div (
      .clk_20b (clk_20b),
      .rst_n   (rst_n),
      .start   (cfg_ok),
      .divisor (cfg_fx),
      .done    (div_done),
      .q       (),
      .n       (div_n)
   );

   always_ff @(posedge clk_20b or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_ARMED: begin
            if (cfg_ok)                 state_nx = S_CALC;
            else if (go && len != '0)   state_nx = S_RUN;
         end
         S_CALC:  if (div_done)         state_nx = S_ARMED;
         S_RUN:   if (abort || last)    state_nx = S_ARMED;
         default:                       state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_20b or negedge rst_n) begin
      if (!rst_n) begin
         len      <= '0;
         period_n <= '0;
         cfg_err  <= 1'b0;
         cnt      <= '0;
         smp_cnt  <= '0;
         ad_clk   <= 1'b0;
         smp_stb  <= 1'b0;
         done     <= 1'b0;
      end else begin
         ad_clk  <= clk_nx;
         smp_stb <= clk_nx && !ad_clk;
         done    <= (go && len == '0)
                    || (state == S_RUN && last && !abort);
         if (hs) begin
            cfg_err <= fx_bad;
            if (!fx_bad) len <= cfg_len;
         end
         if (state == S_CALC && div_done) period_n <= div_n;
         if (state == S_RUN) begin
            cnt <= (cnt == period_n - 1'b1) ? '0 : cnt + 1'b1;
            if (clk_nx && !ad_clk) smp_cnt <= smp_cnt + 1'b1;
         end else begin
            cnt     <= '0;
            smp_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// Self-checking bench for ad_sample_ctrl: closed-form timing model
// compared every cycle, plus directed literal checks.
module tb_ad_sample_ctrl;

   localparam longint CLK   = 200_000_000;
   localparam longint NMIN  = 4;
   localparam int     LEN_W = 16;
   localparam int MI = 0, MC = 1, MA = 2, MR = 3;

`ifdef AD_ROUND_EN
   localparam longint N3M = 67;
`else
   localparam longint N3M = 66;
`endif

   logic             clk_20b = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      cfg_fx = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             cfg_ready;
   logic             busy;
   logic             ad_clk;
   logic             smp_stb;
   logic             done;
   logic             cfg_err;
   logic [31:0]      period_n;

   int     n_chk = 0;
   int     n_fail = 0;
   longint cyc = 0;
   int     stb_cnt = 0;
   int     done_cnt = 0;
   longint last_stb = 0;
   longint stb_gap = 0;

   int     m_mode = MI;
   longint m_t = 0;
   longint m_pn = 0;
   longint m_fx = 0;
   longint m_len = 0;
   bit     m_err = 1'b0;
   bit     m_done = 1'b0;

   ad_sample_ctrl dut (
      .clk_20b   (clk_20b),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_fx    (cfg_fx),
      .cfg_len   (cfg_len),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .ad_clk    (ad_clk),
      .smp_stb   (smp_stb),
      .done      (done),
      .cfg_err   (cfg_err),
      .period_n  (period_n)
   );

   always #5 clk_20b = ~clk_20b;

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic longint exp_n(input longint fx);
`ifdef AD_ROUND_EN
      return (2 * CLK + fx) / (2 * fx);
`else
      return CLK / fx;
`endif
   endfunction

   // model: outputs of a run follow from time since start and N
   initial forever begin
      longint ph;
      bit     e_clk;
      bit     e_stb;
      @(negedge clk_20b);
      cyc++;
      if (!rst_n) begin
         m_mode = MI; m_t = 0; m_pn = 0; m_err = 0;
         m_done = 0; m_len = 0;
      end
      e_clk = 0;
      e_stb = 0;
      if (m_mode == MR && m_t >= 1) begin
         ph    = (m_t - 1) % m_pn;
         e_clk = ph >= m_pn / 2;
         e_stb = ph == m_pn / 2;
      end
      chk("busy", busy, longint'(m_mode == MC || m_mode == MR));
      chk("cfg_ready", cfg_ready, longint'(m_mode == MI || m_mode == MA));
      chk("period_n", period_n, m_pn);
      chk("cfg_err", cfg_err, m_err);
      chk("done", done, m_done);
      chk("ad_clk", ad_clk, e_clk);
      chk("smp_stb", smp_stb, e_stb);
      if (smp_stb === 1'b1) begin
         stb_cnt++;
         stb_gap  = cyc - last_stb;
         last_stb = cyc;
      end
      if (done === 1'b1) done_cnt++;
      if (rst_n) begin
         m_done = 0;
         case (m_mode)
            MI, MA: begin
               if (cfg_valid) begin
                  if (cfg_fx == 0 || longint'(cfg_fx) > CLK / NMIN) m_err = 1;
                  else begin
                     m_err = 0; m_fx = cfg_fx; m_len = cfg_len;
                     m_mode = MC; m_t = 0;
                  end
               end else if (m_mode == MA && start) begin
                  if (m_len == 0) m_done = 1;
                  else begin m_mode = MR; m_t = 0; end
               end
            end
            MC: begin
               if (m_t == 33) begin m_mode = MA; m_pn = exp_n(m_fx); end
               else m_t++;
            end
            MR: begin
               if (abort) m_mode = MA;
               else if (m_t == m_len * m_pn - 1) begin
                  m_mode = MA; m_done = 1;
               end else m_t++;
            end
            default: m_mode = MI;
         endcase
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk_20b);
      #1;
   endtask

   task automatic cfg(input int unsigned fx, input int len);
      cfg_fx    = fx;
      cfg_len   = LEN_W'(len);
      cfg_valid = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_stb(input int k, input int budget, input string nm);
      int b = 0;
      while (stb_cnt < k && b < budget) begin
         tick(1);
         b++;
      end
      chk(nm, longint'(stb_cnt >= k), 1);
   endtask

   initial begin
      int s0;
      int d0;
      tick(3);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_period", period_n, 0);
      chk("rst_adclk", ad_clk, 0);
      rst_n = 1'b1;
      tick(2);

      cfg(1_000_000, 2);
      tick(33);
      chk("calc_busy_33", busy, 1);
      chk("calc_period_old", period_n, 0);
      tick(1);
      chk("period_1m", period_n, 200);
      chk("armed_1m", busy, 0);
      s0 = stb_cnt; d0 = done_cnt;
      pulse_start();
      wait_stb(s0 + 2, 500, "stb_1m_timeout");
      chk("gap_1m", stb_gap, 200);
      tick(250);
      chk("nstb_1m", stb_cnt - s0, 2);
      chk("ndone_1m", done_cnt - d0, 1);

      cfg(3_000_000, 0);
      tick(34);
      chk("period_3m", period_n, N3M);
      d0 = done_cnt;
      pulse_start();
      tick(2);
      chk("len0_done", done_cnt - d0, 1);
      chk("len0_busy", busy, 0);

      cfg(0, 5);
      chk("err_fx0", cfg_err, 1);
      chk("err_fx0_ready", cfg_ready, 1);
      cfg(60_000_000, 5);
      chk("err_fx60m", cfg_err, 1);
      chk("err_period", period_n, N3M);
      abort = 1'b1; tick(1); abort = 1'b0;
      cfg(10_000_000, 4);
      chk("err_clear", cfg_err, 0);
      tick(34);
      chk("period_10m", period_n, 20);

      s0 = stb_cnt; d0 = done_cnt;
      pulse_start();
      tick(10);
      pulse_start();
      tick(80);
      chk("nstb_4", stb_cnt - s0, 4);
      chk("gap_20", stb_gap, 20);
      chk("ndone_4", done_cnt - d0, 1);
      chk("adclk_after", ad_clk, 0);

      cfg_fx = 10_000_000; cfg_len = 100;
      cfg_valid = 1'b1; start = 1'b1;
      tick(1);
      cfg_valid = 1'b0; start = 1'b0;
      chk("cfg_over_start", busy, 1);
      tick(34);
      s0 = stb_cnt; d0 = done_cnt;
      pulse_start();
      wait_stb(s0 + 3, 200, "stb_abort_timeout");
      abort = 1'b1; tick(1); abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_adclk", ad_clk, 0);
      tick(3);
      chk("abort_nodone", done_cnt - d0, 0);
      chk("abort_nstb", stb_cnt - s0, 3);

      s0 = stb_cnt; d0 = done_cnt;
      pulse_start();
      tick(100 * 20 + 5);
      chk("nstb_100", stb_cnt - s0, 100);
      chk("ndone_100", done_cnt - d0, 1);

      s0 = stb_cnt; d0 = done_cnt;
      pulse_start();
      wait_stb(s0 + 2, 200, "stb_rst_timeout");
      rst_n = 1'b0;
      #1;
      chk("rrun_adclk", ad_clk, 0);
      chk("rrun_busy", busy, 0);
      chk("rrun_period", period_n, 0);
      chk("rrun_ready", cfg_ready, 1);
      tick(2);
      rst_n = 1'b1;
      tick(30);
      chk("rrun_nodone", done_cnt - d0, 0);

      cfg(1_000_000, 3);
      tick(10);
      chk("rcalc_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rcalc_busy0", busy, 0);
      chk("rcalc_period", period_n, 0);
      tick(2);
      rst_n = 1'b1;
      tick(40);
      chk("rcalc_period_kept", period_n, 0);
      chk("rcalc_nodone", done_cnt - d0, 0);

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ad_sample_ctrl.md
AD_SAMPLE_CTRL -- requirements
Module: ad_sample_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 200_000_000, clk_20b frequency in Hz.
REQ-002 Parameter NMIN, default 4, minimum ad_clk period in clk_20b cycles.
REQ-003 Parameter LEN_W, default 16, burst length width.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-005 Ports SHALL be as follows:
- clk_20b  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_fx  in  32  requested sample rate, Hz.
- cfg_len  in  LEN_W  samples per burst.
- start  in  1  one-cycle burst trigger.
- abort  in  1  one-cycle burst cancel.
- busy  out  1  high in CALC or RUN.
- ad_clk  out  1  ADC sample clock.
- smp_stb  out  1  one-cycle strobe per ad_clk rising edge.
- done  out  1  one-cycle burst-complete pulse.
- cfg_err  out  1  sticky illegal-config flag.
- period_n  out  32  active period N, in cycles.

Function
REQ-006 The FSM SHALL have states IDLE, CALC, ARMED and RUN.
REQ-007 cfg_ready SHALL be 1 in IDLE and ARMED and 0 in CALC and RUN; a handshake is cfg_valid&&cfg_ready.
REQ-008 On handshake with cfg_fx==0 or cfg_fx>CLK_HZ/NMIN, the block SHALL set cfg_err, keep its state, and leave period_n/cfg_len unchanged.
REQ-009 On a legal handshake, the block SHALL latch cfg_fx/cfg_len, clear cfg_err, and enter CALC.
REQ-010 CALC SHALL compute Q=CLK_HZ/cfg_fx and R=CLK_HZ%cfg_fx with a 32-iteration restoring divider, one bit per cycle.
REQ-011 N SHALL equal Q+1 when 2R>=cfg_fx, else Q (see REQ-026); N is 32-bit unsigned, and 2R SHALL be computed in 33 bits.
REQ-012 period_n SHALL update, and the FSM enter ARMED, exactly 34 cycles after the accepting edge; busy SHALL be 1 throughout.
REQ-013 In ARMED, start with latched len!=0 SHALL enter RUN with period counter cnt=0 and sample count=0.
REQ-014 In ARMED, start with len==0 SHALL pulse done on the next cycle and stay ARMED.
REQ-015 In RUN, cnt SHALL count 0..N-1 and wrap to 0.
REQ-016 ad_clk SHALL be registered as ad_clk <= RUN && cnt>=N/2 (integer halving), giving N-N/2 high and N/2 low cycles per period.
REQ-017 smp_stb SHALL be registered and high only in the cycle where ad_clk goes 0->1; the sample count SHALL increment on each such strobe.
REQ-018 When the sample count equals len and cnt==N-1, the FSM SHALL enter ARMED, drive ad_clk 0, and pulse done for one cycle on the first ARMED cycle.
REQ-019 start and cfg_valid SHALL be ignored in RUN and CALC.
REQ-020 abort in RUN SHALL return to ARMED next cycle with ad_clk=0 and no done; abort elsewhere SHALL be ignored.
REQ-021 abort and the final-period end in the same cycle SHALL resolve in favour of abort.
REQ-022 cfg_valid and start in the same ARMED cycle SHALL resolve in favour of config; start is dropped.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously enter IDLE.
REQ-024 Reset values SHALL be: ad_clk, smp_stb, done, busy, cfg_err = 0; cfg_ready=1; period_n=0; cnt, sample count and divider registers = 0.
REQ-025 Reset mid-CALC or mid-RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-026 With AD_ROUND_EN defined, N SHALL be rounded to nearest per REQ-011; without it, N=Q (truncation) and CALC latency stays 34 cycles.

Structure
REQ-027 Package ad_ctrl_pkg SHALL hold the state enum, the default CLK_HZ, NMIN and the 32-bit width constant.
REQ-028 Sub-module ad_period_div SHALL hold the sequential divider and rounding, with start/done handshake and Q/N outputs.

Verification
REQ-029 fx=1_000_000 -> period_n=200, 34 cycles after accept; ad_clk 100 high/100 low.
REQ-030 fx=3_000_000 -> period_n=67 with AD_ROUND_EN; 66 without.
REQ-031 fx=0, then fx=60_000_000 -> cfg_err=1 each time, state unchanged; then fx=10_000_000 -> cfg_err cleared, period_n=20.
REQ-032 N=20, len=4, start -> exactly 4 smp_stb 20 cycles apart, then one done; ad_clk=0 afterwards.
REQ-033 N=20, len=100, abort after 3rd smp_stb -> ARMED next cycle, ad_clk=0, no done; a new start runs normally.
REQ-034 rst_n low mid-RUN and mid-CALC -> all outputs at reset values immediately; no done.
